// File: rtl/demux_gate_seq.sv
// Gate evaluator that computes one basic logic function in two passes through one shared external 1:2 demux.
// Optional statistics counter (op_count port) is enabled by defining DMXSEQ_STATS_EN.
module demux_gate_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             a,
    input  logic             b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             err,
    output logic             dmx_sel,
    output logic             dmx_i,
    input  logic             dmx_y0,
    input  logic             dmx_y1
`ifdef DMXSEQ_STATS_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ST1  = 2'd1,
        ST2  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t     state_reg;
    logic [2:0] op_reg;
    logic       a_reg;
    logic       b_reg;
    logic       t_reg;
    logic       in_ready_reg;
    logic       out_valid_reg;
    logic       result_reg;
    logic       err_reg;

    // Per-opcode stage-1 drive, tap choice and stage-2 mode, indexed by the latched opcode.
    logic [7:0] s1_sel_vec;
    logic [7:0] s1_i_vec;
    logic [7:0] tap_y1_vec;
    logic [7:0] inv_vec;
    logic [7:0] rsv_vec;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_op
            if (gi == 0 || gi == 2) begin : g_and_nand
                assign s1_sel_vec[gi] = b_reg;
                assign s1_i_vec[gi]   = a_reg;
                assign tap_y1_vec[gi] = 1'b1;
            end else if (gi == 1 || gi == 3) begin : g_or_nor
                assign s1_sel_vec[gi] = b_reg;
                assign s1_i_vec[gi]   = ~a_reg;
                assign tap_y1_vec[gi] = 1'b0;
            end else if (gi == 4) begin : g_not
                assign s1_sel_vec[gi] = a_reg;
                assign s1_i_vec[gi]   = 1'b1;
                assign tap_y1_vec[gi] = 1'b0;
            end else if (gi == 5) begin : g_buf
                assign s1_sel_vec[gi] = a_reg;
                assign s1_i_vec[gi]   = 1'b1;
                assign tap_y1_vec[gi] = 1'b1;
            end else begin : g_rsv
                assign s1_sel_vec[gi] = 1'b0;
                assign s1_i_vec[gi]   = 1'b0;
                assign tap_y1_vec[gi] = 1'b0;
            end
            assign inv_vec[gi] = (gi == 1 || gi == 2) ? 1'b1 : 1'b0;
            assign rsv_vec[gi] = (gi >= 6) ? 1'b1 : 1'b0;
        end
    endgenerate

    logic s1_sel;
    logic s1_i;
    logic tap_y1;
    logic inv_mode;
    logic rsv_op;

    assign s1_sel   = s1_sel_vec[op_reg];
    assign s1_i     = s1_i_vec[op_reg];
    assign tap_y1   = tap_y1_vec[op_reg];
    assign inv_mode = inv_vec[op_reg];
    assign rsv_op   = rsv_vec[op_reg];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= 3'd0;
            a_reg         <= 1'b0;
            b_reg         <= 1'b0;
            t_reg         <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op_reg       <= op;
                        a_reg        <= a;
                        b_reg        <= b;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST1;
                    end
                end
                ST1: begin
                    t_reg     <= tap_y1 ? dmx_y1 : dmx_y0;
                    state_reg <= ST2;
                end
                ST2: begin
                    result_reg    <= dmx_y0;
                    err_reg       <= rsv_op;
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Demux drive depends only on registered state and latched fields.
    always_comb begin
        dmx_sel = 1'b0;
        dmx_i   = 1'b0;
        case (state_reg)
            ST1: begin
                dmx_sel = s1_sel;
                dmx_i   = s1_i;
            end
            ST2: begin
                if (rsv_op) begin
                    dmx_sel = 1'b0;
                    dmx_i   = 1'b0;
                end else if (inv_mode) begin
                    dmx_sel = t_reg;
                    dmx_i   = 1'b1;
                end else begin
                    dmx_sel = 1'b0;
                    dmx_i   = t_reg;
                end
            end
            default: begin
                dmx_sel = 1'b0;
                dmx_i   = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign err       = err_reg;

`ifdef DMXSEQ_STATS_EN
    logic [CNT_W-1:0] op_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (state_reg == HOLD && out_ready) begin
            op_count_reg <= op_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign op_count = op_count_reg;
`endif

endmodule
